spi_dac_sched: RTL
==================

// Module: spi_dac_sched
// PURPOSE
// - Schedules access to the shared spi master (DAC link) for NCH waveform channels plus one clear/shutdown requester.
// - Picks one requester, builds a FRAME-bit command word and drives spi_en/spi_data/spi_clr_ctrl.
// - Tracks frame completion through the master's active-low ss and enforces an inter-frame gap.
// - Sits between the channel sample generators and the spi instance.
// PARAMETERS
// NCH    2   number of channel requesters (1..15)
// DW     12  sample width per channel
// FRAME  24  spi word width; must equal the spi "bits" parameter; FRAME >= DW+8
// GAP    4   idle cycles forced between frames (>=1)
// TMO    15  cycles allowed in START for spi_ss to fall before a timeout
// PORTS
// clk           in   1        system clock, rising edge
// rst           in   1        synchronous reset, active-high
// req           in   NCH      level request per channel; held until matching ack
// data          in   NCH*DW   channel i sample is bits [i*DW +: DW]
// ack           out  NCH      1-cycle pulse: channel sample captured
// clr_req       in   1        level request for a clear frame; held until clr_ack
// clr_ack       out  1        1-cycle pulse: clear request captured
// spi_en        out  1        start strobe to the spi master
// spi_clr_ctrl  out  1        selects the clear/shutdown sequence in the spi master
// spi_data      out  FRAME    word to transmit
// spi_ss        in   1        spi master slave-select, low while a frame is active
// busy          out  1        high whenever state != IDLE
// done          out  1        1-cycle pulse: frame finished (ss returned high)
// err           out  1        1-cycle pulse: START timeout
// BEHAVIOUR
// - All registers update on rising clk. On rst=1 at an edge: state=IDLE; ack, clr_ack, spi_en, spi_clr_ctrl, done, err,
//   busy = 0; spi_data = 0; rr_ptr = NCH-1 (channel 0 wins first); gap/timeout counters = 0.
// - Reset mid-frame: the same values apply at the next edge. The interrupted requester gets no ack if not yet acked.
//   No done is pulsed.
// - Frame word for channel i: {4'b0011, i[3:0], sample[DW-1:0], zeros[FRAME-8-DW-1:0]}.
// - Clear frame: all-zero word with spi_clr_ctrl=1.
// - FSM IDLE -> START -> XFER -> GAP -> IDLE.
// - IDLE: clr_req has priority over every req.
//   - Otherwise round-robin: search starts at rr_ptr+1 (mod NCH); the first asserted req wins.
//   - On a grant, next edge: spi_data loaded, matching ack/clr_ack pulses high for exactly 1 cycle, state=START.
//   - rr_ptr <= granted index. rr_ptr does not change on a clear grant.
// - START: spi_en=1; spi_clr_ctrl=1 only for a clear grant.
//   - spi_ss sampled 0 -> XFER next edge, and spi_en drops.
//   - TMO consecutive START cycles with spi_ss=1 -> err pulse, state=GAP. No done.
// - XFER: spi_en=0; spi_clr_ctrl is held. spi_ss sampled 1 -> done pulse on the next cycle, state=GAP.
//   - No timeout applies in XFER.
// - GAP: spi_en=0, spi_clr_ctrl=0; count GAP cycles, then IDLE. A new grant is possible in the first IDLE cycle.
// - spi_data is stable from the START entry edge until GAP is left.
// - Requests: req[i]/clr_req are sampled only in IDLE. Data is captured on the grant edge.
//   A request dropped before grant is ignored. A request still high after its ack is a new request.
// - Simultaneous clr_req and req in IDLE: clear is served first; the channel is served after GAP.
// - Minimum period per frame = 1 (IDLE) + START + XFER + GAP cycles.
// - busy = (state != IDLE), registered with the state.
// TESTING
// - Reset: assert rst 3 cycles with req=2'b11 -> all outputs 0, busy=0, no ack. After release, ch0 is granted first.
// - Single frame, ch1 data=12'hABC, FRAME=24:
//   - spi_data=24'h31ABC0, ack=2'b10 for 1 cycle, spi_en high until ss falls.
//   - done 1 cycle after ss rises; 4 GAP cycles follow.
// - Round-robin: req=2'b11 held continuously -> grants alternate 0,1,0,1 over 4 frames. Each ack is 1 cycle.
// - Priority: clr_req=1 and req=2'b01 in the same IDLE cycle ->
//   - clear frame first (spi_clr_ctrl=1, spi_data=0, clr_ack); ch0 frame follows after GAP.
// - Timeout: spi_ss held 1 after grant -> err pulse after 15 START cycles, no done. FSM returns to IDLE after GAP.
// - Reset mid-XFER: rst pulse while ss=0 -> spi_en, busy, done = 0 next cycle. Scheduler restarts in IDLE.

Source files
------------

// File: rtl/spi_dac_sched_if.sv
// spi_dac_sched_if
// Bundles the signals that pass between the DAC-link scheduler, the channel
// sample generators and the shared spi master.
//   master modport : requester / spi-master side (drives req, data, clr_req, spi_ss)
//   slave modport  : the scheduler itself (drives acks, spi controls, status)
// Signals:
//   req[NCH]        level request per channel, held until ack
//   data[NCH*DW]    channel i sample in bits [i*DW +: DW]
//   ack[NCH]        1-cycle capture pulse per channel
//   clr_req/clr_ack clear-frame request and its 1-cycle capture pulse
//   spi_en          start strobe to the spi master
//   spi_clr_ctrl    selects the clear/shutdown sequence in the spi master
//   spi_data        FRAME-bit word to transmit
//   spi_ss          spi master slave-select, low while a frame is active
//   busy/done/err   scheduler status: not idle / frame finished / start timeout
interface spi_dac_sched_if #(
    parameter int NCH   = 2,
    parameter int DW    = 12,
    parameter int FRAME = 24
);
    logic [NCH-1:0]    req;
    logic [NCH*DW-1:0] data;
    logic [NCH-1:0]    ack;
    logic              clr_req;
    logic              clr_ack;
    logic              spi_en;
    logic              spi_clr_ctrl;
    logic [FRAME-1:0]  spi_data;
    logic              spi_ss;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output req, data, clr_req, spi_ss,
        input  ack, clr_ack, spi_en, spi_clr_ctrl, spi_data, busy, done, err
    );

    modport slave (
        input  req, data, clr_req, spi_ss,
        output ack, clr_ack, spi_en, spi_clr_ctrl, spi_data, busy, done, err
    );
endinterface

// File: rtl/spi_dac_sched.sv
// spi_dac_sched
// Arbitrates the shared spi master (DAC link) between NCH waveform channels and
// one clear/shutdown requester. Clear wins over channels; channels share the
// link round-robin. Each grant builds a FRAME-bit command word, strobes spi_en
// until the master pulls ss low, waits for ss to return high and then enforces
// GAP idle cycles before the next grant. A START that never sees ss fall is
// abandoned after TMO cycles with an err pulse.
// Ports:
//   clk  rising-edge system clock
//   rst  synchronous active-high reset
//   bus  spi_dac_sched_if.slave (request/ack, spi controls, status)
module spi_dac_sched #(
    parameter int NCH   = 2,
    parameter int DW    = 12,
    parameter int FRAME = 24,
    parameter int GAP   = 4,
    parameter int TMO   = 15
) (
    input  logic           clk,
    input  logic           rst,
    spi_dac_sched_if.slave bus
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = $clog2(TMO + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_XFER, S_GAP} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PW-1:0]    r_rr_ptr,  w_rr_ptr_next;
    logic [TW-1:0]    r_tmo_cnt, w_tmo_cnt_next;
    logic [GW-1:0]    r_gap_cnt, w_gap_cnt_next;
    logic [NCH-1:0]   r_ack,     w_ack_next;
    logic             r_clr_ack, w_clr_ack_next;
    logic             r_spi_en,  w_spi_en_next;
    logic             r_clr_ctrl, w_clr_ctrl_next;
    logic [FRAME-1:0] r_spi_data, w_spi_data_next;
    logic             r_busy;
    logic             r_done,    w_done_next;
    logic             r_err,     w_err_next;

    logic             w_grant_valid;
    logic [PW-1:0]    w_grant_idx;
    int               cand;

    // Command word per channel: 0011, channel number, sample, zero padding.
    logic [FRAME-1:0] w_chan_word [NCH];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_word
        assign w_chan_word[gi] =
            FRAME'({4'b0011, 4'(gi), bus.data[gi*DW +: DW]}) << (FRAME - 8 - DW);
    end

    // Round-robin search starting after the last granted channel. The loop
    // runs from the farthest candidate to the nearest so the nearest asserted
    // request is the last assignment and therefore wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        cand          = 0;
        for (int k = NCH; k >= 1; k--) begin
            cand = int'(r_rr_ptr) + k;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            if (bus.req[PW'(cand)]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = PW'(cand);
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= PW'(NCH - 1);
            r_tmo_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_ack      <= '0;
            r_clr_ack  <= 1'b0;
            r_spi_en   <= 1'b0;
            r_clr_ctrl <= 1'b0;
            r_spi_data <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_tmo_cnt  <= w_tmo_cnt_next;
            r_gap_cnt  <= w_gap_cnt_next;
            r_ack      <= w_ack_next;
            r_clr_ack  <= w_clr_ack_next;
            r_spi_en   <= w_spi_en_next;
            r_clr_ctrl <= w_clr_ctrl_next;
            r_spi_data <= w_spi_data_next;
            r_busy     <= (w_state_next != S_IDLE);
            r_done     <= w_done_next;
            r_err      <= w_err_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.clr_req || w_grant_valid) w_state_next = S_START;
            S_START: begin
                if (!bus.spi_ss) begin
                    w_state_next = S_XFER;
                end else if (r_tmo_cnt == TW'(TMO - 1)) begin
                    w_state_next = S_GAP;
                end
            end
            S_XFER:  if (bus.spi_ss) w_state_next = S_GAP;
            S_GAP:   if (r_gap_cnt == GW'(GAP - 1)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_rr_ptr_next   = r_rr_ptr;
        w_tmo_cnt_next  = r_tmo_cnt;
        w_gap_cnt_next  = r_gap_cnt;
        w_ack_next      = '0;
        w_clr_ack_next  = 1'b0;
        w_spi_en_next   = r_spi_en;
        w_clr_ctrl_next = r_clr_ctrl;
        w_spi_data_next = r_spi_data;
        w_done_next     = 1'b0;
        w_err_next      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.clr_req) begin
                    // rr_ptr is left alone so channel fairness is unaffected
                    w_clr_ack_next  = 1'b1;
                    w_spi_en_next   = 1'b1;
                    w_clr_ctrl_next = 1'b1;
                    w_spi_data_next = '0;
                    w_tmo_cnt_next  = '0;
                end else if (w_grant_valid) begin
                    w_ack_next[w_grant_idx] = 1'b1;
                    w_spi_en_next   = 1'b1;
                    w_clr_ctrl_next = 1'b0;
                    w_spi_data_next = w_chan_word[w_grant_idx];
                    w_rr_ptr_next   = w_grant_idx;
                    w_tmo_cnt_next  = '0;
                end
            end
            S_START: begin
                if (!bus.spi_ss) begin
                    w_spi_en_next = 1'b0;
                end else if (r_tmo_cnt == TW'(TMO - 1)) begin
                    w_spi_en_next   = 1'b0;
                    w_clr_ctrl_next = 1'b0;
                    w_err_next      = 1'b1;
                    w_gap_cnt_next  = '0;
                end else begin
                    w_tmo_cnt_next = r_tmo_cnt + TW'(1);
                end
            end
            S_XFER: begin
                if (bus.spi_ss) begin
                    w_done_next     = 1'b1;
                    w_clr_ctrl_next = 1'b0;
                    w_gap_cnt_next  = '0;
                end
            end
            S_GAP: begin
                w_gap_cnt_next = r_gap_cnt + GW'(1);
            end
            default: ;
        endcase
    end

    assign bus.ack          = r_ack;
    assign bus.clr_ack      = r_clr_ack;
    assign bus.spi_en       = r_spi_en;
    assign bus.spi_clr_ctrl = r_clr_ctrl;
    assign bus.spi_data     = r_spi_data;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
endmodule
